// File: rtl/axi4_stream_framer_pkg.sv
// Shared types and helpers for the AXI4-Stream framing blocks.
// The framer FSM state, a constant-foldable clog2 and the final-beat keep mask.
package axi4s_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  localparam int MAX_BYTES = 64;
  localparam logic [MAX_BYTES-1:0] KEEP_ALL = '1;

  function automatic int clog2(input int unsigned v);
    int r;
    r = 0;
    while ((32'd1 << r) < v) begin
      r = r + 1;
    end
    return r;
  endfunction

  // rem==0 means the last beat is full; otherwise the low rem bytes are valid.
  function automatic logic [MAX_BYTES-1:0] keep_mask(input int unsigned rem,
                                                      input int unsigned nbytes);
    logic [MAX_BYTES-1:0] m;
    if (rem == 0) begin
      m = KEEP_ALL >> (MAX_BYTES - nbytes);
    end else begin
      m = (MAX_BYTES'(1) << rem) - MAX_BYTES'(1);
    end
    return m;
  endfunction

endpackage

// File: rtl/axi4_stream_framer_if.sv
// Unframed input stream plus framed AXI4-Stream output, bundled for the framer.
// slave is the framer's own view; master is the view of the source/sink around it.
interface axi4_stream_framer_if #(
  parameter int DATA_BYTES = 4,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 2
) ();

  logic [8*DATA_BYTES-1:0] S_TDATA;
  logic                    S_TVALID;
  logic                    S_TREADY;

  logic [8*DATA_BYTES-1:0] M_TDATA;
  logic                    M_TVALID;
  logic                    M_TREADY;
  logic                    M_TLAST;
  logic [DATA_BYTES-1:0]   M_TKEEP;
  logic [DATA_BYTES-1:0]   M_TSTRB;
  logic [ID_WIDTH-1:0]     M_TID;
  logic [DEST_WIDTH-1:0]   M_TDEST;

  modport slave (
    input  S_TDATA, S_TVALID, M_TREADY,
    output S_TREADY, M_TDATA, M_TVALID, M_TLAST, M_TKEEP, M_TSTRB, M_TID, M_TDEST
  );

  modport master (
    output S_TDATA, S_TVALID, M_TREADY,
    input  S_TREADY, M_TDATA, M_TVALID, M_TLAST, M_TKEEP, M_TSTRB, M_TID, M_TDEST
  );

endinterface

// File: rtl/axi4_stream_framer_skid_buffer.sv
// Two-entry output skid buffer with a registered input ready.
// Ready depends only on occupancy, so the upstream path never sees the downstream ready.
module axi4s_skid_buffer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] i_s_data,
  input  logic         i_s_valid,
  output logic         o_s_ready,
  output logic [W-1:0] o_m_data,
  output logic         o_m_valid,
  input  logic         i_m_ready
);

  logic [W-1:0] r_mem [2];
  logic         r_wr_ptr;
  logic         r_rd_ptr;
  logic [1:0]   r_count;
  logic         r_ready;
  logic [1:0]   w_count_nxt;
  logic         w_push;
  logic         w_pop;

  assign w_push = i_s_valid && r_ready;
  assign w_pop  = (r_count != 2'd0) && i_m_ready;

  always_comb begin
    w_count_nxt = r_count;
    if (w_push && !w_pop) begin
      w_count_nxt = r_count + 2'd1;
    end else if (!w_push && w_pop) begin
      w_count_nxt = r_count - 2'd1;
    end
  end

  // A push while one entry is held writes the other slot, so the head stays stable.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wr_ptr <= 1'b0;
      r_rd_ptr <= 1'b0;
      r_count  <= 2'd0;
      r_ready  <= 1'b0;
    end else begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= i_s_data;
        r_wr_ptr        <= ~r_wr_ptr;
      end
      if (w_pop) begin
        r_rd_ptr <= ~r_rd_ptr;
      end
      r_count <= w_count_nxt;
      r_ready <= (w_count_nxt != 2'd2);
    end
  end

  assign o_s_ready = r_ready;
  assign o_m_data  = r_mem[r_rd_ptr];
  assign o_m_valid = (r_count != 2'd0);

endmodule

// File: rtl/axi4_stream_framer.sv
// AXI4-Stream framer: cuts an unframed stream into frames of cfg_len bytes with
// exact-beat TLAST, partial final TKEEP/TSTRB and per-frame TID/TDEST.
//   state | meaning
//   IDLE  | no frame latched, input not accepted
//   RUN   | frame config latched, beats accepted into the skid buffer
module axi4_stream_framer
  import axi4s_pkg::*;
#(
  parameter int DATA_BYTES = 4,
  parameter int ID_WIDTH   = 8,
  parameter int DEST_WIDTH = 2,
  parameter int LEN_WIDTH  = 32
) (
  input  logic                  ACLK,
  input  logic                  RST,
  input  logic                  cfg_en,
  input  logic [LEN_WIDTH-1:0]  cfg_len,
  input  logic [ID_WIDTH-1:0]   cfg_id,
  input  logic [DEST_WIDTH-1:0] cfg_dest,
  axi4_stream_framer_if.slave   axis,
  output logic [31:0]           frame_cnt,
  output logic                  busy
);

  localparam int LOG2_B = clog2(DATA_BYTES);
  localparam int REM_W  = (LOG2_B > 0) ? LOG2_B : 1;
  localparam int W      = 8*DATA_BYTES + 1 + DATA_BYTES + ID_WIDTH + DEST_WIDTH;
  localparam logic [DATA_BYTES-1:0] KEEP_FULL = KEEP_ALL[DATA_BYTES-1:0];
  localparam logic [LEN_WIDTH:0]    ONE_L     = 1;

  state_t                r_state;
  state_t                w_state_nxt;
  logic                  w_load;
  logic [LEN_WIDTH:0]    r_beats_left;
  logic [LEN_WIDTH:0]    w_ceil;
  logic [REM_W-1:0]      r_rem;
  logic [REM_W-1:0]      w_rem_new;
  logic [ID_WIDTH-1:0]   r_id;
  logic [DEST_WIDTH-1:0] r_dest;
  logic [31:0]           r_frame_cnt;
  logic                  w_cfg_ok;
  logic                  w_skid_ready;
  logic                  w_push;
  logic                  w_last;
  logic [DATA_BYTES-1:0] w_keep;
  logic [W-1:0]          w_in_pkt;
  logic [W-1:0]          w_out_pkt;
  logic                  w_out_valid;

  assign w_cfg_ok = cfg_en && (cfg_len != '0);

  // One extra bit keeps the round-up from overflowing at the maximum length.
  assign w_ceil    = ({1'b0, cfg_len} + (LEN_WIDTH+1)'(DATA_BYTES - 1)) >> LOG2_B;
  assign w_rem_new = (LOG2_B == 0) ? '0 : cfg_len[REM_W-1:0];

  assign axis.S_TREADY = (r_state == RUN) && w_skid_ready;
  assign w_push        = axis.S_TVALID && axis.S_TREADY;
  assign w_last        = (r_beats_left == '0);
  assign w_keep        = w_last ? DATA_BYTES'(keep_mask(32'(r_rem), DATA_BYTES)) : KEEP_FULL;

  always_comb begin
    w_state_nxt = r_state;
    w_load      = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_cfg_ok) begin
          w_state_nxt = RUN;
          w_load      = 1'b1;
        end
      end
      RUN: begin
        // Re-latching on the last beat starts the next frame with no bubble.
        if (w_push && w_last) begin
          if (w_cfg_ok) begin
            w_load = 1'b1;
          end else begin
            w_state_nxt = IDLE;
          end
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      r_state      <= IDLE;
      r_beats_left <= '0;
      r_rem        <= '0;
      r_id         <= '0;
      r_dest       <= '0;
    end else begin
      r_state <= w_state_nxt;
      if (w_load) begin
        r_beats_left <= w_ceil - ONE_L;
        r_rem        <= w_rem_new;
        r_id         <= cfg_id;
        r_dest       <= cfg_dest;
      end else if (w_push) begin
        r_beats_left <= r_beats_left - ONE_L;
      end
    end
  end

  always_ff @(posedge ACLK or posedge RST) begin
    if (RST) begin
      r_frame_cnt <= 32'd0;
    end else if (axis.M_TVALID && axis.M_TREADY && axis.M_TLAST) begin
      r_frame_cnt <= r_frame_cnt + 32'd1;
    end
  end

  assign w_in_pkt = {axis.S_TDATA, w_last, w_keep, r_id, r_dest};

  axi4s_skid_buffer #(
    .W(W)
  ) u_skid (
    .clk       (ACLK),
    .rst       (RST),
    .i_s_data  (w_in_pkt),
    .i_s_valid (w_push),
    .o_s_ready (w_skid_ready),
    .o_m_data  (w_out_pkt),
    .o_m_valid (w_out_valid),
    .i_m_ready (axis.M_TREADY)
  );

  assign {axis.M_TDATA, axis.M_TLAST, axis.M_TKEEP, axis.M_TID, axis.M_TDEST} = w_out_pkt;
  assign axis.M_TSTRB  = axis.M_TKEEP;
  assign axis.M_TVALID = w_out_valid;

  assign frame_cnt = r_frame_cnt;
  assign busy      = (r_state == RUN);

endmodule

// File: doc/axi4_stream_framer.md
Name: axi4_stream_framer

Overview:
Parameterised AXI4-Stream framing stage. It accepts an unframed data stream with a VALID/READY handshake and emits a framed AXI4-Stream master. Framing adds exact-beat TLAST, a partial TKEEP/TSTRB on the final beat, and per-frame TID/TDEST latched from configuration. It sits between the fabric data generator/DMA source and the stream interconnect. Unlike the earlier stream block, it honours TREADY, asserts TLAST on the last data beat itself, and supports byte-granular frame lengths.

Parameters:
DATA_BYTES  4   bytes per beat; TDATA width = 8*DATA_BYTES; power of 2, 1..64
ID_WIDTH  8   TID width
DEST_WIDTH  2   TDEST width
LEN_WIDTH  32   frame length field width (bytes)

Ports:
ACLK  in  1  clock
RST  in  1  asynchronous reset, active-high
cfg_en  in  1  framing enable
cfg_len  in  LEN_WIDTH  frame length in bytes
cfg_id  in  ID_WIDTH  TID for next frame
cfg_dest  in  DEST_WIDTH  TDEST for next frame
S_TDATA  in  8*DATA_BYTES  input data
S_TVALID  in  1  input valid
S_TREADY  out  1  input ready
M_TDATA  out  8*DATA_BYTES  output data
M_TVALID  out  1  output valid
M_TREADY  in  1  output ready
M_TLAST  out  1  last beat of frame
M_TKEEP  out  DATA_BYTES  byte keep
M_TSTRB  out  DATA_BYTES  byte strobe, always equal to M_TKEEP
M_TID  out  ID_WIDTH  frame ID
M_TDEST  out  DEST_WIDTH  frame destination
frame_cnt  out  32  completed frames; wraps modulo 2^32
busy  out  1  high while in RUN

Behaviour:
- Reset: RST asserts asynchronously. It forces IDLE, clears the skid buffer, clears frame_cnt and sets all outputs to 0, including S_TREADY and M_TVALID.
- FSM states: IDLE and RUN.
- IDLE to RUN: occurs when cfg_en=1 and cfg_len!=0.
  - On the transition, latch len_q=cfg_len, id_q=cfg_id and dest_q=cfg_dest.
  - Load beats_left = ceil(len_q/DATA_BYTES) - 1.
  - Load rem = len_q mod DATA_BYTES.
- cfg_len=0: the block stays in IDLE with S_TREADY=0. No beats are accepted.
- RUN: S_TREADY equals the skid buffer's input ready.
  - An accepted beat is one with S_TVALID & S_TREADY.
  - Each accepted beat is pushed with sideband {last=(beats_left==0), keep, id_q, dest_q}.
- keep: all ones, except on the last beat when rem!=0, where keep = (1<<rem)-1 (the low bytes are valid).
- Beat counting: beats_left decrements by 1 per accepted beat.
- RUN to IDLE: occurs on acceptance of the last beat.
  - If cfg_en=1 and cfg_len!=0 in that cycle, the FSM re-latches config and stays in RUN with no bubble.
- cfg_* changes mid-frame are ignored until the next frame boundary.
- Deasserting cfg_en mid-frame does not abort the frame. The frame completes, then the FSM goes to IDLE.
- frame_cnt increments when M_TVALID & M_TREADY & M_TLAST, i.e. on the output side.
- Output stage (two-entry skid buffer):
  - Latency from input accept to M_TVALID is 1 cycle when the buffer is empty.
  - Full throughput of one beat per cycle with M_TREADY held high.
  - S_TREADY is registered. It depends only on buffer occupancy, never combinationally on M_TREADY.
- AXI rules:
  - Once M_TVALID=1, M_TDATA and all sideband signals hold stable until M_TREADY=1.
  - M_TVALID never depends on M_TREADY.
- Simultaneous push and pop when the buffer is full by one entry: both occur and occupancy is unchanged.
- Width rules:
  - ceil is computed as (len_q + DATA_BYTES - 1) >> log2(DATA_BYTES), using LEN_WIDTH+1 bits to avoid overflow at the maximum length.
  - rem uses log2(DATA_BYTES) bits; when DATA_BYTES=1, rem is always 0.
- busy = (state==RUN).

Decomposition:
- Shared package axi4s_pkg:
  - state enum {IDLE, RUN}
  - function clog2
  - function keep_mask(rem, DATA_BYTES)
  - localparam KEEP_ALL
- One sub-module: axi4s_skid_buffer.
  - Parameter W, set to the packed data+last+keep+id+dest width.
  - Two entries, registered ready.
  - Reused by later stream blocks.

Test Plan:
- DATA_BYTES=4, cfg_len=10, cfg_id=8'h5A, cfg_dest=2, M_TREADY=1 -> 3 beats with TKEEP F,F,3; TLAST on beat 3 only; TID=5A and TDEST=2 on all beats; frame_cnt=1.
- cfg_len=8 -> 2 beats, TKEEP F,F, TLAST on beat 2. cfg_len=1 -> 1 beat, TKEEP=1, TLAST=1.
- Back-to-back frames: cfg_len=8 held with continuous S_TVALID -> no idle cycle between frames on M_TVALID; TLAST every 2nd beat; frame_cnt=4 after 8 beats.
- M_TREADY random 50% with an incrementing TDATA pattern -> all beats arrive in order with none lost or duplicated; outputs stable while stalled; S_TREADY falls only when 2 entries are held.
- Mid-frame change: with cfg_len=12 latched, set cfg_len=4 and cfg_id=1 after beat 1 -> the current frame is still 3 beats with the old ID; the next frame is 1 beat with TID=1.
- Reset: assert RST after beat 2 of a 3-beat frame -> all outputs 0 immediately, frame_cnt=0; after release the next frame starts cleanly with a full beat count.
